// File: rtl/hps_fpga_button_pio.sv
// Avalon-MM input PIO: synchronizes and debounces board inputs, captures edges
// and raises a maskable level interrupt to the HPS over the lightweight bridge.
module hps_fpga_button_pio #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_db;
  logic [WIDTH-1:0] r_db_d;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] r_irqmask;

  logic             w_wr;
  logic             w_rd;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_ev;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_wr     = chipselect && !write_n;
  assign w_rd     = chipselect && !read_n;
  assign w_unused = &{1'b0, writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync  <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync  <= r_sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_db <= '0;
        else          r_db <= r_sync;
      end
    end else begin : g_debounce
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] r_cnt [WIDTH];

      // Counter tracks consecutive cycles where sync disagrees with db;
      // any agreement (a bounce back) restarts it.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
          r_db <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (r_sync[i] == r_db[i]) begin
              r_cnt[i] <= '0;
            end else if (r_cnt[i] == LAST) begin
              r_db[i]  <= r_sync[i];
              r_cnt[i] <= '0;
            end else begin
              r_cnt[i] <= r_cnt[i] + CW'(1);
            end
          end
        end
      end
    end
  endgenerate

  assign w_rise = r_db & ~r_db_d;
  assign w_fall = ~r_db & r_db_d;

  always_comb begin
    w_ev = w_rise | w_fall;
    if (EDGE_TYPE == 0)      w_ev = w_rise;
    else if (EDGE_TYPE == 1) w_ev = w_fall;
  end

  assign w_clr = (w_wr && address == 2'd2) ? writedata[WIDTH-1:0] : '0;

  // New events are OR-ed in after the clear so a same-cycle set is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_db_d    <= '0;
      r_edge    <= '0;
      r_irqmask <= '0;
    end else begin
      r_db_d <= r_db;
      r_edge <= (r_edge & ~w_clr) | w_ev;
      if (w_wr && address == 2'd1) r_irqmask <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      2'd0:    w_rdata[WIDTH-1:0] = r_db;
      2'd1:    w_rdata[WIDTH-1:0] = r_irqmask;
      2'd2:    w_rdata[WIDTH-1:0] = r_edge;
      default: w_rdata[WIDTH-1:0] = r_sync;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  readdata <= '0;
    else if (w_rd) readdata <= w_rdata;
  end

  assign irq = |(r_edge & r_irqmask);

endmodule

// File: tb/tb_hps_fpga_button_pio.sv
// Bench for hps_fpga_button_pio: three instances (rising, falling, any edge)
// share one bus and one in_port and are checked against a window-based model.
module tb_hps_fpga_button_pio;

  localparam int D = 4;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;

  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  int total = 0;
  int bad   = 0;

  hps_fpga_button_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rd0), .in_port(in_port), .irq(irq0));

  hps_fpga_button_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rd1), .in_port(in_port), .irq(irq1));

  hps_fpga_button_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rd2), .in_port(in_port), .irq(irq2));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    bad++;
    $fatal(1, "watchdog expired");
  end

  // model: m_hist[j] is in_port as sampled j+1 edges before the current one
  logic [7:0]  m_hist [8];
  logic [7:0]  m_db, m_db_d, m_mask;
  logic [7:0]  m_ec [3];
  logic [31:0] m_rd [3];

  always @(posedge clk or negedge reset_n) begin : model_b
    logic [7:0] db_next, rise, fall, clr;
    logic       flip;
    if (!reset_n) begin
      for (int j = 0; j < 8; j++) m_hist[j] = '0;
      m_db = '0; m_db_d = '0; m_mask = '0;
      for (int k = 0; k < 3; k++) begin
        m_ec[k] = '0;
        m_rd[k] = '0;
      end
    end else begin
      rise = m_db & ~m_db_d;
      fall = ~m_db & m_db_d;
      // a bit flips once the last D synchronized samples all disagree with it
      for (int i = 0; i < 8; i++) begin
        flip = 1'b1;
        for (int j = 1; j <= D; j++) if (m_hist[j][i] == m_db[i]) flip = 1'b0;
        db_next[i] = flip ? ~m_db[i] : m_db[i];
      end
      if (chipselect && !read_n) begin
        for (int k = 0; k < 3; k++) begin
          case (address)
            2'd0:    m_rd[k] = {24'h0, m_db};
            2'd1:    m_rd[k] = {24'h0, m_mask};
            2'd2:    m_rd[k] = {24'h0, m_ec[k]};
            default: m_rd[k] = {24'h0, m_hist[1]};
          endcase
        end
      end
      clr = (chipselect && !write_n && address == 2'd2) ? writedata[7:0] : 8'h00;
      m_ec[0] = (m_ec[0] & ~clr) | rise;
      m_ec[1] = (m_ec[1] & ~clr) | fall;
      m_ec[2] = (m_ec[2] & ~clr) | rise | fall;
      if (chipselect && !write_n && address == 2'd1) m_mask = writedata[7:0];
      for (int j = 7; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = in_port;
      m_db_d = m_db;
      m_db   = db_next;
    end
  end

  // scoreboard: every cycle, outputs of all instances against the model
  always @(negedge clk) begin : compare_b
    logic [31:0] act_rd [3];
    logic        act_irq [3];
    logic        exp_irq;
    act_rd[0] = rd0;  act_rd[1] = rd1;  act_rd[2] = rd2;
    act_irq[0] = irq0; act_irq[1] = irq1; act_irq[2] = irq2;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (act_rd[k] !== m_rd[k]) begin
        bad++;
        $display("FAIL model_readdata u%0d t=%0t: actual=%h required=%h", k, $time, act_rd[k], m_rd[k]);
      end
      exp_irq = |(m_ec[k] & m_mask);
      total++;
      if (act_irq[k] !== exp_irq) begin
        bad++;
        $display("FAIL model_irq u%0d t=%0t: actual=%b required=%b", k, $time, act_irq[k], exp_irq);
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    tick(1);
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; read_n = 1'b1;
    write_n = 1'b1; writedata = '0; in_port = 8'h00;
    tick(3);
    reset_n = 1'b1;

    // reset values
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a));
      chk($sformatf("reset_rd_addr%0d", a), rd0, 32'h0);
      chk($sformatf("reset_rd_any_addr%0d", a), rd2, 32'h0);
    end
    chk("reset_irq", {31'h0, irq0}, 32'h0);

    // debounce latency: sync at 2 edges, db at 6, edge capture at 7
    in_port = 8'h01; chipselect = 1'b1; read_n = 1'b0; address = 2'd3;
    tick(2); chk("sync_edge2", rd0, 32'h0);
    tick(1); chk("sync_edge3", rd0, 32'h1);
    address = 2'd0;
    tick(3); chk("db_edge6", rd0, 32'h0);
    tick(1); chk("db_edge7", rd0, 32'h1);
    address = 2'd2;
    tick(1); chk("ec_rise", rd0, 32'h1);
    chk("ec_fall_inst", rd1, 32'h0);
    chk("irq_masked", {31'h0, irq0}, 32'h0);
    chipselect = 1'b0; read_n = 1'b1;

    // bounce rejection on bit 1
    bus_write(2'd2, 32'hFF);
    in_port = 8'h03; tick(3);
    in_port = 8'h01; tick(1);
    in_port = 8'h03; tick(3);
    in_port = 8'h01; tick(10);
    bus_read(2'd0); chk("bounce_db", rd0, 32'h1);
    bus_read(2'd2); chk("bounce_ec", rd0, 32'h0);
    chk("bounce_ec_any", rd2, 32'h0);

    // interrupt
    bus_write(2'd1, 32'h1);
    in_port = 8'h00; tick(10);
    bus_write(2'd2, 32'hFF);
    in_port = 8'h01;
    tick(6); chk("irq_before_edge", {31'h0, irq0}, 32'h0);
    tick(1); chk("irq_rise", {31'h0, irq0}, 32'h1);
    bus_write(2'd2, 32'h1);
    chk("irq_clear", {31'h0, irq0}, 32'h0);
    in_port = 8'h00; tick(8);
    in_port = 8'h01; tick(8);
    chk("irq_again", {31'h0, irq0}, 32'h1);
    bus_write(2'd1, 32'h0);
    chk("irq_mask_off", {31'h0, irq0}, 32'h0);
    bus_read(2'd2); chk("ec_kept", rd0, 32'h1);
    bus_write(2'd1, 32'h1);
    chk("irq_remask", {31'h0, irq0}, 32'h1);

    // set/clear collision on bit 2, with a read of the same register
    bus_write(2'd2, 32'hFF);
    in_port = 8'h05;
    tick(6);
    address = 2'd2; writedata = 32'h4; chipselect = 1'b1; write_n = 1'b0; read_n = 1'b0;
    tick(1); chk("rw_same_cycle", rd0, 32'h0);
    write_n = 1'b1;
    tick(1); chk("collision_set_wins", rd0, 32'h4);
    chipselect = 1'b0; read_n = 1'b1;

    // falling-edge instance
    in_port = 8'hFF; tick(10);
    bus_write(2'd2, 32'hFF);
    in_port = 8'h00; tick(10);
    bus_read(2'd2);
    chk("fall_all", rd1, 32'hFF);
    chk("fall_on_rise_inst", rd0, 32'h0);

    // any-edge instance, both edges of bit 3
    bus_write(2'd2, 32'hFF);
    in_port = 8'h08; tick(10);
    bus_read(2'd2); chk("any_rise", rd2, 32'h8);
    bus_write(2'd2, 32'hFF);
    in_port = 8'h00; tick(10);
    bus_read(2'd2); chk("any_fall", rd2, 32'h8);
    chk("rise_inst_no_fall", rd0, 32'h0);

    // reset in the middle of a debounce
    in_port = 8'h20; tick(3);
    reset_n = 1'b0; tick(2);
    chk("rst_readdata", rd0, 32'h0);
    reset_n = 1'b1; tick(2);
    bus_read(2'd0); chk("rst_db_discarded", rd0, 32'h0);
    tick(8);
    bus_read(2'd0); chk("rst_db_after", rd0, 32'h20);

    // read-only level register, upper bits read zero
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_read(2'd0); chk("ro_write_ignored", rd0, 32'h20);
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1); chk("mask_upper_zero", rd0, 32'hFF);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
